// File: rtl/sram_read_checker.sv
// SRAM read-pass checker: walks every address, waits READ_WAIT cycles per read,
// compares against the address-derived pattern and records error statistics.
module sram_read_checker #(
  parameter int                   ADDR_BITS   = 20,
  parameter int                   DATA_BITS   = 16,
  parameter int                   READ_WAIT   = 2,
  parameter logic [DATA_BITS-1:0] PATTERN_XOR = '0,
  parameter int                   ERR_BITS    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 ce_n,
  output logic                 oe_n,
  output logic                 we_n,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_BITS-1:0]  error_count,
  output logic [ADDR_BITS-1:0] first_err_addr,
  output logic [DATA_BITS-1:0] first_err_data
);

  typedef enum logic [1:0] {IDLE, READ, CHECK, DONE} state_t;

  localparam logic [3:0] LAST_WAIT = 4'(READ_WAIT - 1);

  state_t               state_q, state_d;
  logic [3:0]           cnt;
  logic [DATA_BITS-1:0] rd_data;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [DATA_BITS-1:0] expected;
  logic                 mismatch;
  logic                 addr_last;

  assign expected  = DATA_BITS'(rd_addr) ^ PATTERN_XOR;
  assign mismatch  = (rd_data != expected);
  assign addr_last = (addr == '1);
  assign we_n      = 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    ce_n    = 1'b1;
    oe_n    = 1'b1;
    case (state_q)
      IDLE:  if (start) state_d = READ;
      READ: begin
        busy = 1'b1;
        ce_n = 1'b0;
        oe_n = 1'b0;
        if (cnt == LAST_WAIT) state_d = CHECK;
      end
      CHECK: begin
        busy    = 1'b1;
        ce_n    = 1'b0;
        oe_n    = 1'b0;
        state_d = addr_last ? DONE : READ;
      end
      DONE:  if (start) state_d = READ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr           <= '0;
      cnt            <= '0;
      rd_data        <= '0;
      rd_addr        <= '0;
      error_count    <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            addr           <= '0;
            cnt            <= '0;
            error_count    <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
          end else if (state_q == DONE) begin
            // results register one cycle after entering DONE
            done <= 1'b1;
            pass <= (error_count == '0);
          end
        end
        READ: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST_WAIT) begin
            rd_data <= data_in;
            rd_addr <= addr;
          end
        end
        CHECK: begin
          if (mismatch) begin
            if (error_count != '1) error_count <= error_count + ERR_BITS'(1);
            if (error_count == '0) begin
              first_err_addr <= rd_addr;
              first_err_data <= rd_data;
            end
          end
          if (!addr_last) begin
            addr <= addr + ADDR_BITS'(1);
            cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_read_checker.sv
// Directed bench: three small checker instances (plain, 2-bit error counter,
// XOR pattern) driven by a behavioural SRAM model with selectable corruption.
module tb_sram_read_checker;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // mode 0: correct pattern, 1: corrupt addr 5 (0xAA) and 9 (0x00),
  // 2: always 0xFF, 3: plain address without XOR
  function automatic logic [7:0] model(input int mode, input logic [3:0] a, input logic [7:0] x);
    case (mode)
      0:       return {4'b0, a} ^ x;
      1:       return (a == 4'd5) ? 8'hAA : (a == 4'd9) ? 8'h00 : ({4'b0, a} ^ x);
      2:       return 8'hFF;
      default: return {4'b0, a};
    endcase
  endfunction

  int mode_a = 0, mode_b = 0, mode_c = 0;
  logic start_a = 0, start_b = 0, start_c = 0;

  logic [3:0] addr_a, addr_b, addr_c;
  logic ce_a, ce_b, ce_c, oe_a, oe_b, oe_c, we_a, we_b, we_c;
  logic busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c;
  logic [7:0] ec_a, ec_c;
  logic [1:0] ec_b;
  logic [3:0] fea_a, fea_b, fea_c;
  logic [7:0] fed_a, fed_b, fed_c;
  logic [7:0] din_a, din_b, din_c;

  always_comb begin
    din_a = model(mode_a, addr_a, 8'h00);
    din_b = model(mode_b, addr_b, 8'h00);
    din_c = model(mode_c, addr_c, 8'h5A);
  end

  sram_read_checker #(.ADDR_BITS(4), .DATA_BITS(8), .READ_WAIT(2), .PATTERN_XOR(8'h00), .ERR_BITS(8)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .addr(addr_a), .ce_n(ce_a), .oe_n(oe_a), .we_n(we_a),
    .data_in(din_a), .busy(busy_a), .done(done_a), .pass(pass_a), .error_count(ec_a),
    .first_err_addr(fea_a), .first_err_data(fed_a));

  sram_read_checker #(.ADDR_BITS(4), .DATA_BITS(8), .READ_WAIT(2), .PATTERN_XOR(8'h00), .ERR_BITS(2)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .addr(addr_b), .ce_n(ce_b), .oe_n(oe_b), .we_n(we_b),
    .data_in(din_b), .busy(busy_b), .done(done_b), .pass(pass_b), .error_count(ec_b),
    .first_err_addr(fea_b), .first_err_data(fed_b));

  sram_read_checker #(.ADDR_BITS(4), .DATA_BITS(8), .READ_WAIT(2), .PATTERN_XOR(8'h5A), .ERR_BITS(8)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .addr(addr_c), .ce_n(ce_c), .oe_n(oe_c), .we_n(we_c),
    .data_in(din_c), .busy(busy_c), .done(done_c), .pass(pass_c), .error_count(ec_c),
    .first_err_addr(fea_c), .first_err_data(fed_c));

  task automatic peek(input int d, output logic dn, output logic [3:0] ad, output logic oe,
                      output logic bz, output logic [7:0] ec);
    case (d)
      0:       begin dn = done_a; ad = addr_a; oe = oe_a; bz = busy_a; ec = ec_a; end
      1:       begin dn = done_b; ad = addr_b; oe = oe_b; bz = busy_b; ec = {6'b0, ec_b}; end
      default: begin dn = done_c; ad = addr_c; oe = oe_c; bz = busy_c; ec = ec_c; end
    endcase
  endtask

  task automatic set_start(input int d, input logic v);
    case (d)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  // Pulse start, verify the address walk and the start-to-done latency (49).
  task automatic run(input int d, input bit glitch);
    logic dn, oe, bz;
    logic [3:0] ad;
    logic [7:0] ec;
    int k, seq_bad;
    @(negedge clk);
    set_start(d, 1'b1);
    @(posedge clk);
    #1;
    set_start(d, 1'b0);
    peek(d, dn, ad, oe, bz, ec);
    check("start_busy", bz, 1);
    check("start_addr", ad, 0);
    check("start_oe", oe, 0);
    check("start_done_clr", dn, 0);
    check("start_ec_clr", ec, 0);
    k = 0;
    seq_bad = 0;
    dn = 1'b0;
    while (!dn && k < 200) begin
      @(posedge clk);
      #1;
      k++;
      if (glitch && k == 10) set_start(d, 1'b1);
      if (glitch && k == 11) set_start(d, 1'b0);
      peek(d, dn, ad, oe, bz, ec);
      if (k < 48 && (ad != 4'(k / 3) || oe != 1'b0 || bz != 1'b1)) seq_bad++;
    end
    check("addr_walk", seq_bad, 0);
    check("latency", k, 49);
  endtask

  initial begin
    #3;
    check("rst_addr", addr_a, 0);
    check("rst_ce", ce_a, 1);
    check("rst_oe", oe_a, 1);
    check("rst_we", we_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_ec", ec_a, 0);
    @(negedge clk);
    reset = 1'b1;

    // clean pass
    mode_a = 0;
    run(0, 1'b0);
    check("p1_pass", pass_a, 1);
    check("p1_ec", ec_a, 0);
    check("p1_ce", ce_a, 1);
    check("p1_oe", oe_a, 1);
    check("p1_busy", busy_a, 0);

    // two corrupted addresses, back-to-back from DONE
    mode_a = 1;
    run(0, 1'b0);
    check("p2_ec", ec_a, 2);
    check("p2_fea", fea_a, 5);
    check("p2_fed", fed_a, 8'hAA);
    check("p2_pass", pass_a, 0);

    // clean again, start pulse mid-pass must be ignored
    mode_a = 0;
    run(0, 1'b1);
    check("p3_pass", pass_a, 1);
    check("p3_ec", ec_a, 0);
    check("p3_fea", fea_a, 0);
    check("p3_fed", fed_a, 0);

    // saturating 2-bit counter
    mode_b = 2;
    run(1, 1'b0);
    check("sat_ec", ec_b, 3);
    check("sat_pass", pass_b, 0);
    check("sat_fea", fea_b, 0);
    check("sat_fed", fed_b, 8'hFF);

    // XOR pattern
    mode_c = 0;
    run(2, 1'b0);
    check("xor_pass", pass_c, 1);
    check("xor_ec", ec_c, 0);
    mode_c = 3;
    run(2, 1'b0);
    check("xor_plain_ec", ec_c, 16);
    check("xor_plain_pass", pass_c, 0);
    check("xor_plain_fed", fed_c, 0);

    // asynchronous reset in the middle of a pass at addr 7
    mode_a = 1;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    for (int i = 0; i < 100 && addr_a != 4'd7; i++) begin
      @(posedge clk);
      #1;
    end
    check("mid_addr7", addr_a, 7);
    check("mid_ec", ec_a, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mrst_addr", addr_a, 0);
    check("mrst_ce", ce_a, 1);
    check("mrst_oe", oe_a, 1);
    check("mrst_busy", busy_a, 0);
    check("mrst_ec", ec_a, 0);
    check("mrst_fea", fea_a, 0);
    check("mrst_fed", fed_a, 0);
    @(negedge clk);
    reset = 1'b1;
    mode_a = 0;
    run(0, 1'b0);
    check("post_rst_pass", pass_a, 1);
    check("post_rst_ec", ec_a, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_read_checker.md
# sram_read_checker

Read-side counterpart of the SRAM test address generator: after the write pass has filled the SRAM with an address-derived pattern, this block walks every address from 0 to all-ones, issues an asynchronous SRAM read at each, and compares the returned data against the expected pattern. It reports pass/fail, a saturating error count, and the first failing address and data. It sits between the SRAM test top-level sequencer and the SRAM pins, with the SRAM data bus in input mode.

## Interface

- ADDR_BITS, 20, SRAM address width
- DATA_BITS, 16, SRAM data width
- READ_WAIT, 2, cycles address/oe_n are held before data_in is sampled; legal range 1..15
- PATTERN_XOR, 0 (DATA_BITS wide), constant XORed into the expected pattern
- ERR_BITS, 16, error counter width

- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse that begins a read pass
- addr  output  ADDR_BITS  SRAM address
- ce_n  output  1  SRAM chip enable, active-low
- oe_n  output  1  SRAM output enable, active-low
- we_n  output  1  SRAM write enable; constant 1
- data_in  input  DATA_BITS  SRAM read data
- busy  output  1  pass in progress
- done  output  1  pass complete; held until the next start
- pass  output  1  valid with done; 1 = zero mismatches
- error_count  output  ERR_BITS  mismatch count, saturates at all-ones
- first_err_addr  output  ADDR_BITS  address of first mismatch
- first_err_data  output  DATA_BITS  data read at first mismatch

## Operation

- expected(a) = zero-extended or truncated a to DATA_BITS, XOR PATTERN_XOR.
- FSM states: IDLE, READ, CHECK, DONE.
- IDLE: ce_n=1, oe_n=1, busy=0. On start: addr<=0, error_count<=0, first_err_*<=0, done<=0, pass<=0, wait counter<=0; go to READ.
- READ: ce_n=0, oe_n=0, busy=1, addr held. Wait counter increments each cycle. On the cycle where counter == READ_WAIT-1, capture data_in into rd_data and the current addr into rd_addr, then go to CHECK.
- CHECK: ce_n=0, oe_n=0, busy=1. Compare rd_data against expected(rd_addr).
  - On mismatch, error_count increments, or holds if it is already all-ones.
  - On the first mismatch of the pass (error_count == 0 before the increment), load first_err_addr=rd_addr and first_err_data=rd_data.
  - If addr == all-ones: go to DONE.
  - Otherwise: addr<=addr+1, counter<=0, go to READ.
- DONE: ce_n=1, oe_n=1, busy=0, done=1. pass = (final error_count == 0). Results hold.
  - start in DONE behaves as start in IDLE; the pass restarts and done clears on the following edge.
- start while busy is ignored.
- addr never wraps past all-ones within a pass.
- error_count saturates; it never wraps to 0.
- pass must be 0 whenever error_count is nonzero, including after saturation.

## Timing

- Reset (reset low, asynchronous) drives these values immediately, in any state including mid-pass, and the FSM returns to IDLE:
  - addr=0, ce_n=1, oe_n=1, we_n=1
  - busy=0, done=0, pass=0
  - error_count=0, first_err_addr=0, first_err_data=0
- Reset release is synchronous to clk. First start is accepted on the first rising edge with reset high.
- start sampled at edge T: busy=1, addr=0, oe_n=0 from T+1.
- Cycles per address: READ_WAIT (READ) + 1 (CHECK).
- Address changes one cycle after the CHECK edge. data_in is sampled READ_WAIT cycles after the address becomes stable.
- Full pass: start edge to done=1 is 1 + 2^ADDR_BITS * (READ_WAIT+1) cycles.
- Result visibility after the final CHECK edge:
  - error_count and first_err_* update on the CHECK edge.
  - done and pass are visible one cycle after the final CHECK edge.
- start and reset deasserting in the same cycle: reset wins; start is ignored on that edge.

## Test plan

- ADDR_BITS=4, DATA_BITS=8, READ_WAIT=2, SRAM model returns expected(addr) -> 16 addresses visited in order 0..15, each held 3 cycles; done at cycle 49 after start; pass=1; error_count=0; ce_n and oe_n return to 1.
- Same config, model corrupts addr 5 (returns 0xAA) and addr 9 -> error_count=2, first_err_addr=5, first_err_data=0xAA, pass=0.
- ERR_BITS=2, model returns 0xFF at every address -> error_count=3 (saturated), pass=0, first_err_addr=0.
- PATTERN_XOR=0x5A, model returns addr^0x5A -> pass=1. Model returns the plain address -> 16 errors.
- Reset asserted at addr=7 mid-READ -> all outputs take reset values immediately. A later start runs a full pass from addr 0. start pulses during busy do not perturb addr.
- Back-to-back passes: start in DONE -> done drops next cycle, counters clear, and the second pass result is independent of the first.
